// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns PC, instruction register, retired count and halt flag.
// One memory read per instruction; the fetched word is held until the control unit acks it.
module fetch_unit #(
  parameter int unsigned       WORD_W   = 16,
  parameter int unsigned       CNT_W    = 16,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_read,
  output logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic [WORD_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ack,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [WORD_W-1:0] pc,
  output logic [CNT_W-1:0]  num_inst,
  output logic              is_halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t              state_q, state_nxt;
  logic [WORD_W-1:0]   pc_q, pc_nxt;
  logic [WORD_W-1:0]   inst_q, inst_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic                halted_q, halted_nxt;
  logic                mem_read_q;
  logic                inst_valid_q;

  // State and datapath registers; strobes are flopped from the next state so they track state exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      cnt_q        <= '0;
      halted_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      pc_q         <= pc_nxt;
      inst_q       <= inst_nxt;
      cnt_q        <= cnt_nxt;
      halted_q     <= halted_nxt;
      mem_read_q   <= (state_nxt == S_REQ);
      inst_valid_q <= (state_nxt == S_HOLD);
    end
  end

  // Next-state and register updates
  always_comb begin
    state_nxt  = state_q;
    pc_nxt     = pc_q;
    inst_nxt   = inst_q;
    cnt_nxt    = cnt_q;
    halted_nxt = halted_q;
    case (state_q)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (mem_ready) begin
          inst_nxt  = mem_data;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (inst_ack) begin
          cnt_nxt = cnt_q + CNT_W'(1);
          // halt takes priority over redirect and leaves pc on the HLT instruction
          if (halt) begin
            halted_nxt = 1'b1;
            state_nxt  = S_HALT;
          end else begin
            pc_nxt    = redirect ? redirect_pc : pc_q + WORD_W'(1);
            state_nxt = S_REQ;
          end
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_read   = mem_read_q;
  assign mem_addr   = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign num_inst   = cnt_q;
  assign is_halted  = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: acts as memory and control unit, predicting each instruction's
// fetch/hold/ack sequence from PC arithmetic with randomized delays and input noise.
module tb_fetch_unit;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              mem_read;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_data = '0;
  logic              mem_ready = 1'b0;
  logic [WORD_W-1:0] inst;
  logic              inst_valid;
  logic              inst_ack = 1'b0;
  logic              redirect = 1'b0;
  logic [WORD_W-1:0] redirect_pc = '0;
  logic              halt = 1'b0;
  logic [WORD_W-1:0] pc;
  logic [CNT_W-1:0]  num_inst;
  logic              is_halted;

  fetch_unit #(.WORD_W(WORD_W), .CNT_W(CNT_W), .RESET_PC('0)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .inst(inst), .inst_valid(inst_valid), .inst_ack(inst_ack),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .pc(pc), .num_inst(num_inst), .is_halted(is_halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural state only
  logic [WORD_W-1:0] exp_pc;
  logic [WORD_W-1:0] exp_inst;
  logic [CNT_W-1:0]  exp_cnt;
  logic              exp_halted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_arch(input string tag);
    check_eq({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    check_eq({tag, "_cnt"}, 32'(num_inst), 32'(exp_cnt));
    check_eq({tag, "_halted"}, 32'(is_halted), 32'(exp_halted));
  endtask

  // Async reset asserted between edges, then released on a negedge with mem_ready high
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    exp_pc = '0; exp_cnt = '0; exp_inst = '0; exp_halted = 1'b0;
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst", 32'(inst), 32'd0);
    check_arch("rst");
    mem_ready = 1'b1; inst_ack = 1'b1; halt = 1'b0; redirect = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("rel_mem_read", 32'(mem_read), 32'd0);
    @(posedge clk);
  endtask

  // Fetch one instruction: d stall cycles before mem_ready, a wait cycles before ack
  task automatic fetch_one(input int d, input int a, input bit redir, input bit hlt,
                           input logic [WORD_W-1:0] rpc, input logic [WORD_W-1:0] data);
    for (int i = 0; i <= d; i++) begin
      @(negedge clk);
      check_eq("req_mem_read", 32'(mem_read), 32'd1);
      check_eq("req_addr", 32'(mem_addr), 32'(exp_pc));
      check_eq("req_inst_valid", 32'(inst_valid), 32'd0);
      mem_ready   = (i == d);
      mem_data    = (i == d) ? data : WORD_W'($urandom);
      inst_ack    = 1'($urandom);
      redirect    = 1'($urandom);
      halt        = 1'($urandom);
      redirect_pc = WORD_W'($urandom);
    end
    for (int j = 0; j <= a; j++) begin
      @(negedge clk);
      check_eq("hold_inst_valid", 32'(inst_valid), 32'd1);
      check_eq("hold_mem_read", 32'(mem_read), 32'd0);
      check_eq("hold_inst", 32'(inst), 32'(data));
      check_arch("hold");
      mem_ready = 1'($urandom);
      mem_data  = WORD_W'($urandom);
      inst_ack  = (j == a);
      if (j == a) begin
        redirect = redir; halt = hlt; redirect_pc = rpc;
      end else begin
        redirect = 1'($urandom); halt = 1'($urandom); redirect_pc = WORD_W'($urandom);
      end
    end
    exp_cnt  = exp_cnt + 1'b1;
    exp_inst = data;
    if (hlt) exp_halted = 1'b1;
    else if (redir) exp_pc = rpc;
    else exp_pc = exp_pc + 1'b1;
  endtask

  task automatic req_stall(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check_eq("stall_mem_read", 32'(mem_read), 32'd1);
      check_eq("stall_addr", 32'(mem_addr), 32'(exp_pc));
      mem_ready = 1'b0;
      inst_ack  = 1'($urandom);
    end
  endtask

  task automatic check_halted(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("halt_mem_read", 32'(mem_read), 32'd0);
      check_eq("halt_inst_valid", 32'(inst_valid), 32'd0);
      check_eq("halt_inst", 32'(inst), 32'(exp_inst));
      check_arch("halt");
      mem_ready = 1'($urandom); inst_ack = 1'($urandom);
      redirect  = 1'($urandom); halt = 1'($urandom);
      mem_data  = WORD_W'($urandom); redirect_pc = WORD_W'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    // Back-to-back best-case fetches
    for (int i = 0; i < 4; i++) fetch_one(0, 0, 1'b0, 1'b0, '0, 16'h1234);
    // Slow memory: mem_read held across stalls
    fetch_one(3, 1, 1'b0, 1'b0, '0, WORD_W'($urandom));
    // Redirects, and redirect noise without ack
    fetch_one(1, 0, 1'b1, 1'b0, 16'h0005, WORD_W'($urandom));
    fetch_one(0, 2, 1'b1, 1'b0, 16'h0040, WORD_W'($urandom));
    fetch_one(0, 3, 1'b0, 1'b0, '0, WORD_W'($urandom));
    fetch_one(0, 0, 1'b0, 1'b0, '0, WORD_W'($urandom));
    // PC wrap at the top of the address space
    fetch_one(0, 0, 1'b1, 1'b0, 16'hFFFF, WORD_W'($urandom));
    fetch_one(0, 0, 1'b0, 1'b0, '0, WORD_W'($urandom));
    fetch_one(0, 0, 1'b0, 1'b0, '0, WORD_W'($urandom));
    // Random traffic long enough to wrap num_inst
    for (int i = 0; i < 300; i++)
      fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0), 1'b0, WORD_W'($urandom), WORD_W'($urandom));
    // Halt together with redirect at pc 7
    fetch_one(0, 0, 1'b1, 1'b0, 16'h0007, WORD_W'($urandom));
    fetch_one(1, 1, 1'b1, 1'b1, 16'h0099, WORD_W'($urandom));
    check_halted(12);
    // Restart, advance pc, then reset in the middle of a fetch
    do_reset();
    for (int i = 0; i < 3; i++)
      fetch_one(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, 1'b0,
                '0, WORD_W'($urandom));
    req_stall(2);
    do_reset();
    fetch_one(0, 0, 1'b0, 1'b0, '0, WORD_W'($urandom));
    fetch_one(2, 1, 1'b0, 1'b0, '0, WORD_W'($urandom));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
